// File: rtl/path_writer.sv
// path_writer
// Walks the predecessor vector left by the Dijkstra core from dest_node back
// to source_node. It writes every node on the way, then the path length, to
// memory through the shared write port.
//
// Memory layout written at result_address (address arithmetic wraps):
//   +0     path length L (0 when the walk failed)
//   +k     k-th node counting from dest (k = 1..L), so +1 = dest, +L = source
//
// Ports
//   clock, reset           single clock; reset is synchronous, active-low
//   start                  1-cycle request, honoured only in IDLE
//   source_node, dest_node path end points, sampled on start
//   number_of_nodes        graph size, sampled on start
//   result_address         output buffer base, sampled on start
//   prev_index / prev_value predecessor lookup; value valid 1 cycle after index
//   mem_write_enable/_ready, mem_addr, mem_write_data   memory write port
//   busy, done, path_error status; path_error valid with done, held until next start
//   dbg_state              current FSM state, for observation only
//
// Write handshake: mem_write_enable is a valid. While it is high, mem_addr and
// mem_write_data are held stable. The write retires at the first posedge where
// mem_write_ready is high. After that the enable either drops or already carries
// the next write, so back-to-back writes are possible.
module path_writer #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 8,
  parameter int MADDR_WIDTH = 16,
  parameter int MDATA_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] source_node,
  input  logic [INDEX_WIDTH-1:0] dest_node,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] result_address,
  output logic [INDEX_WIDTH-1:0] prev_index,
  input  logic [INDEX_WIDTH-1:0] prev_value,
  output logic                   mem_write_enable,
  input  logic                   mem_write_ready,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  output logic [MDATA_WIDTH-1:0] mem_write_data,
  output logic                   busy,
  output logic                   done,
  output logic                   path_error,
  output logic [2:0]             dbg_state
);

  localparam logic [INDEX_WIDTH-1:0] NO_PREVIOUS_NODE = '1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE_NODE = 3'd1,
    S_LOOKUP     = 3'd2,
    S_CHECK      = 3'd3,
    S_WRITE_LEN  = 3'd4,
    S_DONE       = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] src_q, src_d;
  logic [INDEX_WIDTH-1:0] n_q, n_d;
  logic [MADDR_WIDTH-1:0] base_q, base_d;
  logic [INDEX_WIDTH-1:0] cur_q, cur_d;
  logic [INDEX_WIDTH:0]   count_q, count_d;
  logic                   err_q, err_d;
  logic [INDEX_WIDTH-1:0] prev_index_q, prev_index_d;
  logic                   we_q, we_d;
  logic [MADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MDATA_WIDTH-1:0] data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   perr_q, perr_d;

  logic                   bad_start;
  logic [INDEX_WIDTH:0]   count_inc;
  logic [MADDR_WIDTH-1:0] next_node_addr;

  // A graph larger than MAX_NODES is outside what the core can have produced,
  // so it is rejected like an out-of-range end point.
  assign bad_start = (dest_node >= number_of_nodes) ||
                     (source_node >= number_of_nodes) ||
                     (number_of_nodes > INDEX_WIDTH'(MAX_NODES));

  assign count_inc = count_q + 1'b1;

  // Used in CHECK, where count_q already counts the nodes written so far.
  assign next_node_addr = base_q + MADDR_WIDTH'(1) + MADDR_WIDTH'(count_q);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      n_q          <= '0;
      base_q       <= '0;
      cur_q        <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      prev_index_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      n_q          <= n_d;
      base_q       <= base_d;
      cur_q        <= cur_d;
      count_q      <= count_d;
      err_q        <= err_d;
      prev_index_q <= prev_index_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      perr_q       <= perr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    n_d          = n_q;
    base_d       = base_q;
    cur_d        = cur_q;
    count_d      = count_q;
    err_d        = err_q;
    prev_index_d = prev_index_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    perr_d       = perr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = source_node;
          n_d     = number_of_nodes;
          base_d  = result_address;
          cur_d   = dest_node;
          count_d = '0;
          perr_d  = 1'b0;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          if (bad_start) begin
            // Nothing to walk: go straight to writing a zero length word.
            err_d   = 1'b1;
            state_d = S_WRITE_LEN;
            addr_d  = result_address;
            data_d  = '0;
          end else begin
            err_d   = 1'b0;
            state_d = S_WRITE_NODE;
            addr_d  = result_address + MADDR_WIDTH'(1);
            data_d  = MDATA_WIDTH'(dest_node);
          end
        end
      end

      S_WRITE_NODE: begin
        if (mem_write_ready) begin
          count_d = count_inc;
          if (cur_q == src_q) begin
            // Reached the source: the length write follows back-to-back.
            state_d = S_WRITE_LEN;
            addr_d  = base_q;
            data_d  = MDATA_WIDTH'(count_inc);
          end else begin
            we_d         = 1'b0;
            prev_index_d = cur_q;
            state_d      = S_LOOKUP;
          end
        end
      end

      // prev_value for the new prev_index arrives one cycle later.
      S_LOOKUP: state_d = S_CHECK;

      S_CHECK: begin
        we_d = 1'b1;
        // A walk that has already visited number_of_nodes nodes without
        // reaching the source must be going round a cycle.
        if ((prev_value == NO_PREVIOUS_NODE) || (count_q == {1'b0, n_q})) begin
          err_d   = 1'b1;
          state_d = S_WRITE_LEN;
          addr_d  = base_q;
          data_d  = '0;
        end else begin
          cur_d   = prev_value;
          state_d = S_WRITE_NODE;
          addr_d  = next_node_addr;
          data_d  = MDATA_WIDTH'(prev_value);
        end
      end

      S_WRITE_LEN: begin
        if (mem_write_ready) begin
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          perr_d  = err_q;
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign prev_index       = prev_index_q;
  assign mem_write_enable = we_q;
  assign mem_addr         = addr_q;
  assign mem_write_data   = data_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign path_error       = perr_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_path_writer.sv
// Bench for path_writer: a table of directed cases, randomized walks over
// random predecessor vectors and hand-written reset sequences.
module tb_path_writer;

  localparam int IW   = 8;
  localparam int MAW  = 16;
  localparam int MDW  = 16;
  localparam int MAXN = 16;
  localparam int W    = MAW + MDW;

  logic           clock;
  logic           reset;
  logic           start;
  logic [IW-1:0]  source_node;
  logic [IW-1:0]  dest_node;
  logic [IW-1:0]  number_of_nodes;
  logic [MAW-1:0] result_address;
  logic [IW-1:0]  prev_index;
  logic [IW-1:0]  prev_value;
  logic           mem_write_enable;
  logic           mem_write_ready;
  logic [MAW-1:0] mem_addr;
  logic [MDW-1:0] mem_write_data;
  logic           busy;
  logic           done;
  logic           path_error;
  logic [2:0]     dbg_state;

  path_writer #(
    .MAX_NODES  (MAXN),
    .INDEX_WIDTH(IW),
    .MADDR_WIDTH(MAW),
    .MDATA_WIDTH(MDW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .source_node     (source_node),
    .dest_node       (dest_node),
    .number_of_nodes (number_of_nodes),
    .result_address  (result_address),
    .prev_index      (prev_index),
    .prev_value      (prev_value),
    .mem_write_enable(mem_write_enable),
    .mem_write_ready (mem_write_ready),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .busy            (busy),
    .done            (done),
    .path_error      (path_error),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];

  logic [IW-1:0] prev_mem [0:255];
  int   ready_mode;      // 0 always ready, 1 pattern 0,0,1, 2 random, 3 never
  int   wait_cnt;
  logic stall_pend;
  logic [W-1:0] stall_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Predecessor lookup of the core: registered, one cycle of latency.
  always @(posedge clock) prev_value <= prev_mem[prev_index];

  // Memory side, evaluated mid-cycle while DUT outputs are stable: check that a
  // stalled write held still, choose ready for the coming edge and log the
  // write that will retire there.
  always @(negedge clock) begin
    if (stall_pend && reset)
      check("stall_hold", 64'({mem_write_enable, mem_addr, mem_write_data}),
            64'({1'b1, stall_word}));
    case (ready_mode)
      0: mem_write_ready = 1'b1;
      1: begin
        if (mem_write_enable) begin
          if (wait_cnt < 2) begin
            mem_write_ready = 1'b0;
            wait_cnt++;
          end else begin
            mem_write_ready = 1'b1;
            wait_cnt = 0;
          end
        end else begin
          mem_write_ready = 1'b0;
        end
      end
      2: mem_write_ready = 1'($urandom_range(0, 1));
      default: mem_write_ready = 1'b0;
    endcase
    if (reset && mem_write_enable && mem_write_ready)
      act_q.push_back({mem_addr, mem_write_data});
    stall_pend = reset && mem_write_enable && !mem_write_ready;
    stall_word = {mem_addr, mem_write_data};
  end

  // ---------------- reference model ----------------
  // Path walk straight from the memory-layout rules: list of (addr, data) writes.
  task automatic model(input logic [IW-1:0] src, input logic [IW-1:0] dst,
                       input logic [IW-1:0] n, input logic [MAW-1:0] base,
                       output logic err, output int nodes);
    logic [IW-1:0] cur;
    int k;
    bit fin;
    exp_q.delete();
    err = 1'b0;
    nodes = 0;
    if (dst >= n || src >= n || int'(n) > MAXN) begin
      err = 1'b1;
      exp_q.push_back({base, MDW'(0)});
    end else begin
      cur = dst;
      k = 0;
      fin = 0;
      while (!fin) begin
        exp_q.push_back({base + MAW'(1 + k), MDW'(cur)});
        k++;
        if (cur == src) begin
          exp_q.push_back({base, MDW'(k)});
          fin = 1;
        end else if (prev_mem[cur] == 8'hFF || k == int'(n)) begin
          err = 1'b1;
          exp_q.push_back({base, MDW'(0)});
          fin = 1;
        end else begin
          cur = prev_mem[cur];
        end
      end
      nodes = k;
    end
  endtask

  task automatic load_tab(input int t);
    for (int i = 0; i < 256; i++) prev_mem[i] = 8'hFF;
    if (t == 0) begin
      prev_mem[1] = 8'd0; prev_mem[2] = 8'd1; prev_mem[4] = 8'd2;
    end else if (t == 1) begin
      prev_mem[1] = 8'd2; prev_mem[2] = 8'd1;
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left at posedge + 1.
  task automatic run_txn(input string tag, input logic [IW-1:0] src, input logic [IW-1:0] dst,
                         input logic [IW-1:0] n, input logic [MAW-1:0] base,
                         output int edges, output int nw, output logic [MDW-1:0] last_data,
                         output logic perr);
    logic err;
    int nodes;
    int exp_edges;
    int m;
    model(src, dst, n, base, err, nodes);
    act_q.delete();
    wait_cnt = 0;
    source_node = src;
    dest_node = dst;
    number_of_nodes = n;
    result_address = base;
    start = 1'b1;
    edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        check($sformatf("%s_busy", tag), 64'(busy), 64'd1);
      end
      // A second start while busy, with different inputs, must be ignored.
      if (edges == 3 && busy && !done) begin
        source_node = ~src;
        dest_node = 8'd0;
        number_of_nodes = 8'd1;
        result_address = ~base;
        start = 1'b1;
      end
      if (edges == 4) start = 1'b0;
    end while (!done && edges < 3000);
    start = 1'b0;
    if (!done) check($sformatf("%s_timeout", tag), 64'd0, 64'd1);
    perr = path_error;
    check($sformatf("%s_perr", tag), 64'(path_error), 64'(err));
    check($sformatf("%s_busy_at_done", tag), 64'(busy), 64'd0);
    if (ready_mode == 0) begin
      exp_edges = (nodes == 0) ? 2 : (err ? 3 * nodes + 2 : 3 * nodes);
      check($sformatf("%s_latency", tag), 64'(edges), 64'(exp_edges));
    end
    @(posedge clock); #1;
    check($sformatf("%s_done_pulse", tag), 64'(done), 64'd0);
    check($sformatf("%s_perr_hold", tag), 64'(path_error), 64'(err));
    nw = act_q.size();
    last_data = (nw > 0) ? act_q[nw-1][MDW-1:0] : '1;
    check($sformatf("%s_nwrites", tag), 64'(nw), 64'(exp_q.size()));
    m = (nw < exp_q.size()) ? nw : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_write%0d", tag, i), 64'(act_q[i]), 64'(exp_q[i]));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [IW-1:0]  src;
    logic [IW-1:0]  dst;
    logic [IW-1:0]  n;
    logic [MAW-1:0] base;
    int             tab;
    int             rmode;
    logic [MDW-1:0] exp_len;
    logic           exp_perr;
    int             exp_nw;
    int             exp_edges;   // -1: not checked (backpressure)
  } vec_t;

  vec_t vecs[8];

  initial begin
    int edges, nw;
    logic [MDW-1:0] last;
    logic perr;
    logic [IW-1:0] n, s, d;

    //        src    dst    n      base       tab rm len     perr  nw  edges
    vecs[0] = '{8'd0, 8'd0, 8'd0, 16'h0000, 0, 0, 16'd0, 1'b0, 0, 0};
    vecs[0] = '{8'd3, 8'd3, 8'd5, 16'h0100, 0, 0, 16'd1, 1'b0, 2, 3};   // trivial
    vecs[1] = '{8'd0, 8'd4, 8'd5, 16'h0200, 0, 0, 16'd4, 1'b0, 5, 12};  // normal
    vecs[2] = '{8'd0, 8'd3, 8'd5, 16'h0200, 0, 0, 16'd0, 1'b1, 2, 5};   // unreachable
    vecs[3] = '{8'd0, 8'd1, 8'd3, 16'h0300, 1, 0, 16'd0, 1'b1, 4, 11};  // cycle guard
    vecs[4] = '{8'd0, 8'd4, 8'd5, 16'h0400, 0, 1, 16'd4, 1'b0, 5, -1};  // backpressure
    vecs[5] = '{8'd0, 8'd7, 8'd5, 16'h0500, 0, 0, 16'd0, 1'b1, 1, 2};   // bad dest
    vecs[6] = '{8'd0, 8'd4, 8'd5, 16'hFFFE, 0, 1, 16'd4, 1'b0, 5, -1};  // base wrap
    vecs[7] = '{8'd0, 8'd1, 8'd17, 16'h0600, 0, 0, 16'd0, 1'b1, 1, 2};  // graph too big

    reset = 1'b0;
    start = 1'b0;
    source_node = '0;
    dest_node = '0;
    number_of_nodes = '0;
    result_address = '0;
    ready_mode = 0;
    wait_cnt = 0;
    stall_pend = 1'b0;
    stall_word = '0;
    mem_write_ready = 1'b1;
    load_tab(0);

    // Reset, with a start held during reset that must be ignored.
    source_node = 8'd3; dest_node = 8'd3; number_of_nodes = 8'd5; result_address = 16'h0100;
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_we", 64'(mem_write_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_perr", 64'(path_error), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_data", 64'(mem_write_data), 64'd0);
    check("rst_prev_index", 64'(prev_index), 64'd0);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clock); #1;
    check("start_in_reset_busy", 64'(busy), 64'd0);
    check("start_in_reset_we", 64'(mem_write_enable), 64'd0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      load_tab(vecs[i].tab);
      ready_mode = vecs[i].rmode;
      run_txn($sformatf("v%0d", i), vecs[i].src, vecs[i].dst, vecs[i].n, vecs[i].base,
              edges, nw, last, perr);
      check($sformatf("v%0d_len_word", i), 64'(last), 64'(vecs[i].exp_len));
      check($sformatf("v%0d_perr_tab", i), 64'(perr), 64'(vecs[i].exp_perr));
      check($sformatf("v%0d_nw_tab", i), 64'(nw), 64'(vecs[i].exp_nw));
      if (vecs[i].exp_edges >= 0)
        check($sformatf("v%0d_edges_tab", i), 64'(edges), 64'(vecs[i].exp_edges));
    end

    // Reset during a stalled node write: the write is abandoned.
    load_tab(0);
    ready_mode = 3;
    act_q.delete();
    source_node = 8'd0; dest_node = 8'd4; number_of_nodes = 8'd5; result_address = 16'h0200;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    check("midrst_pre_we", 64'(mem_write_enable), 64'd1);
    check("midrst_pre_addr", 64'(mem_addr), 64'h201);
    reset = 1'b0;
    @(posedge clock); #1;
    check("midrst_we", 64'(mem_write_enable), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_addr", 64'(mem_addr), 64'd0);
    check("midrst_data", 64'(mem_write_data), 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_no_writes", 64'(act_q.size()), 64'd0);
    ready_mode = 0;
    run_txn("after_rst", 8'd0, 8'd4, 8'd5, 16'h0200, edges, nw, last, perr);
    check("after_rst_len", 64'(last), 64'd4);

    // Random walks over random predecessor vectors.
    for (int t = 0; t < 40; t++) begin
      n = IW'($urandom_range(1, MAXN));
      for (int i = 0; i < 256; i++) prev_mem[i] = 8'hFF;
      for (int i = 0; i < int'(n); i++)
        prev_mem[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : IW'($urandom_range(0, int'(n) - 1));
      s = IW'($urandom_range(0, int'(n) - 1));
      d = IW'($urandom_range(0, int'(n) - 1));
      if ($urandom_range(0, 9) == 0) d = n + IW'($urandom_range(0, 3));
      ready_mode = (t % 2 == 0) ? 0 : 2;
      run_txn($sformatf("rnd%0d", t), s, d, n, MAW'($urandom), edges, nw, last, perr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
